// File: rtl/inst_loader.sv
// inst_loader: boot loader turning a big-endian byte stream into sequential instruction-memory writes; holds the CPU in reset until done.
// Latency: a word is written the cycle after its 4th byte is accepted; done rises two cycles after the final data byte (one after the checksum byte).
// Backpressure: in_ready high only in byte-accepting states, no stall between words; optional trailing XOR checksum under LOADER_CHECKSUM_EN.
module inst_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_CNT_HI, S_CNT_LO, S_WORD, S_FIN, S_CHK, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_CNT_HI, S_CNT_LO, S_WORD, S_FIN, S_DONE, S_ERR} state_t;
`endif

  state_t            state, state_n;
  logic              accept;
  logic              in_ready_n;
  logic [7:0]        cnt_hi;
  logic [15:0]       count;
  logic [ADDR_W:0]   wcnt, wcnt_inc;
  logic [1:0]        idx;
  logic [23:0]       shreg;
  logic [16:0]       new_count;
  logic [16:0]       depth;
  logic              last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign accept    = in_valid && in_ready;
  assign new_count = {1'b0, cnt_hi, in_data};
  assign depth     = 17'd1 << ADDR_W;
  // Word counter is one bit wider than the address so N = depth compares without wrapping.
  assign wcnt_inc  = wcnt + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (17'(wcnt_inc) == {1'b0, count});

  assign done    = (state == S_DONE);
  assign err     = (state == S_ERR);
  assign cpu_rst = (state != S_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CNT_HI;
    else     state <= state_n;
  end

  // Next-state decode; in_ready is registered from the next state so it is low out of reset.
  always_comb begin
    state_n    = state;
    in_ready_n = 1'b0;
    case (state)
      S_CNT_HI: if (accept) state_n = S_CNT_LO;
      S_CNT_LO: begin
        if (accept) begin
          if (new_count > depth)        state_n = S_ERR;
          else if (new_count == 17'd0)  state_n = S_FIN;
          else                          state_n = S_WORD;
        end
      end
      S_WORD: if (accept && idx == 2'd3 && last_word) state_n = S_FIN;
`ifdef LOADER_CHECKSUM_EN
      S_FIN: state_n = S_CHK;
      S_CHK: if (accept) state_n = (in_data == csum) ? S_DONE : S_ERR;
`else
      S_FIN: state_n = S_DONE;
`endif
      S_DONE, S_ERR: if (reload) state_n = S_CNT_HI;
      default: state_n = S_CNT_HI;
    endcase
`ifdef LOADER_CHECKSUM_EN
    in_ready_n = (state_n == S_CNT_HI) || (state_n == S_CNT_LO) ||
                 (state_n == S_WORD)   || (state_n == S_CHK);
`else
    in_ready_n = (state_n == S_CNT_HI) || (state_n == S_CNT_LO) || (state_n == S_WORD);
`endif
  end

  // Byte assembly, word counting and the single-cycle memory write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt_hi    <= '0;
      count     <= '0;
      wcnt      <= '0;
      idx       <= '0;
      shreg     <= '0;
    end else begin
      in_ready <= in_ready_n;
      mem_we   <= 1'b0;
      case (state)
        S_CNT_HI: if (accept) cnt_hi <= in_data;
        S_CNT_LO: begin
          if (accept) begin
            count <= {cnt_hi, in_data};
            wcnt  <= '0;
            idx   <= '0;
          end
        end
        S_WORD: begin
          if (accept) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_wdata <= {shreg, in_data};
              mem_addr  <= wcnt[ADDR_W-1:0];
              wcnt      <= wcnt_inc;
            end else begin
              shreg <= {shreg[15:0], in_data};
            end
          end
        end
        S_DONE, S_ERR: begin
          if (reload) begin
            wcnt <= '0;
            idx  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of data bytes only; restarted when a new count has been taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              csum <= '0;
    else if (state == S_CNT_LO && accept) csum <= '0;
    else if (state == S_WORD && accept)   csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_inst_loader.sv
`timescale 1ns/1ps
module tb_inst_loader;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  localparam int DONE_LAT = CHK_EN ? 1 : 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  inst_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  stm[$];
  logic [31:0] exp_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_addr_q[$];
  bit          wr_rdy_q[$];
  logic [31:0] seen_mem [DEPTH];

  // write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mem_we) begin
      wr_data_q.push_back(mem_wdata);
      wr_addr_q.push_back(int'(mem_addr));
      wr_rdy_q.push_back(in_ready);
      seen_mem[mem_addr] = mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i, input logic [31:0] w0, input logic [31:0] w1);
    return (i == 0) ? w0 : (i == 1) ? w1 : w0 + 32'(i) * w1;
  endfunction

  // byte stream: 16-bit BE count, BE words, optional XOR checksum (bad flips it)
  task automatic build(input int n, input logic [31:0] w0, input logic [31:0] w1, input bit bad);
    logic [7:0]  x;
    logic [31:0] w;
    x = 8'h00;
    stm.delete();
    stm.push_back(8'(n >> 8));
    stm.push_back(8'(n));
    if (n <= DEPTH) begin
      for (int i = 0; i < n; i++) begin
        w = word_of(i, w0, w1);
        for (int b = 3; b >= 0; b--) begin
          stm.push_back(w[8*b +: 8]);
          x ^= w[8*b +: 8];
        end
      end
      if (CHK_EN) stm.push_back(bad ? (x ^ 8'h01) : x);
    end
  endtask

  // reference: parse the stream into expected writes and final status
  task automatic model(output int n_exp, output bit err_exp);
    int n;
    logic [7:0] x;
    exp_q.delete();
    n = int'({stm[0], stm[1]});
    if (n > DEPTH) begin
      n_exp = 0;
      err_exp = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({stm[2+4*i], stm[3+4*i], stm[4+4*i], stm[5+4*i]});
      for (int b = 0; b < 4; b++) x ^= stm[2+4*i+b];
    end
    n_exp = n;
    err_exp = CHK_EN && (stm[2+4*n] != x);
  endtask

  // mode 0: valid always; 1: valid every other cycle; 2: random valid + reload noise
  task automatic send(input int mode, input int max_bytes, output int stalls);
    int i, guard;
    i = 0; guard = 0; stalls = 0;
    while (i < max_bytes && guard < 2000) begin
      @(negedge clk);
      guard++;
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? guard[0] : ($urandom_range(0, 2) != 0);
      reload   = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
      in_data  = stm[i];
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) i++;
    end
    if (i < max_bytes) check("send_timeout", i, max_bytes);
  endtask

  task automatic finish_load(output int lat);
    @(negedge clk);
    in_valid = 1'b0;
    reload = 1'b0;
    lat = 1;
    while (!(done || err) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_reload();
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
  endtask

  task automatic run(input int mode, output int lat, output int stalls);
    if (done || err) do_reload();
    wr_data_q.delete(); wr_addr_q.delete(); wr_rdy_q.delete();
    send(mode, stm.size(), stalls);
    finish_load(lat);
  endtask

  task automatic compare_model(input string tag, input int lat);
    int ne;
    bit ee, ok;
    model(ne, ee);
    check({tag, "_nwr"}, wr_data_q.size(), ne);
    ok = 1'b1;
    for (int i = 0; i < ne && i < wr_data_q.size(); i++)
      if (wr_addr_q[i] != i || wr_data_q[i] !== exp_q[i] || (i < ne - 1 && !wr_rdy_q[i])) ok = 1'b0;
    check({tag, "_writes"}, ok, 1);
    check({tag, "_done"}, done, !ee);
    check({tag, "_err"}, err, ee);
    check({tag, "_cpu_rst"}, cpu_rst, ee);
    check({tag, "_lat"}, lat, (ne == 0 && ee) || CHK_EN ? 1 : 2);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  typedef struct {
    int          n;
    logic [31:0] w0, w1;
    int          mode;
    bit          exp_err;
    int          exp_lat;
    int          exp_nwr;
    logic [31:0] exp_last;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int lat, stalls, n, mode;
    bit bad;
    string tag;

    tbl[0] = '{2,   32'h20080005, 32'h01095020, 0, 1'b0, DONE_LAT, 2,  32'h01095020};
    tbl[1] = '{0,   32'h0,        32'h0,        0, 1'b0, DONE_LAT, 0,  32'h0};
    tbl[2] = '{17,  32'h0,        32'h0,        0, 1'b1, 1,        0,  32'h0};
    tbl[3] = '{1,   32'hDEADBEEF, 32'h0,        1, 1'b0, DONE_LAT, 1,  32'hDEADBEEF};
    tbl[4] = '{16,  32'h10000000, 32'h00000001, 0, 1'b0, DONE_LAT, 16, 32'h1000000F};
    tbl[5] = '{256, 32'h0,        32'h0,        1, 1'b1, 1,        0,  32'h0};
    tbl[6] = '{15,  32'hAAAA5555, 32'h00000100, 2, 1'b0, DONE_LAT, 15, 32'hAAAA6355};

    for (int i = 0; i < DEPTH; i++) seen_mem[i] = 32'h0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    @(negedge clk); @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);
    check("por_first_edge_in_ready", in_ready, 1);
    check("por_first_edge_cpu_rst", cpu_rst, 1);

    for (int t = 0; t < 7; t++) begin
      tag = $sformatf("tbl%0d", t);
      build(tbl[t].n, tbl[t].w0, tbl[t].w1, 1'b0);
      run(tbl[t].mode, lat, stalls);
      check({tag, "_nwr"}, wr_data_q.size(), tbl[t].exp_nwr);
      if (tbl[t].exp_nwr > 0 && wr_data_q.size() > 0) begin
        check({tag, "_last_data"}, wr_data_q[wr_data_q.size()-1], tbl[t].exp_last);
        check({tag, "_last_addr"}, wr_addr_q[wr_addr_q.size()-1], tbl[t].exp_nwr - 1);
      end
      check({tag, "_lat"}, lat, tbl[t].exp_lat);
      check({tag, "_err"}, err, tbl[t].exp_err);
      check({tag, "_done"}, done, !tbl[t].exp_err);
      check({tag, "_cpu_rst"}, cpu_rst, tbl[t].exp_err);
      check({tag, "_in_ready_idle"}, in_ready, 0);
      if (tbl[t].mode == 0) check({tag, "_stalls"}, stalls, 0);
      compare_model(tag, lat);
    end

    // reset in the middle of an N=2 load, then a full reload
    build(2, 32'hCAFEF00D, 32'h0BADC0DE, 1'b0);
    if (done || err) do_reload();
    send(0, 6, stalls);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset("midrst");
    check("midrst_word0_kept", seen_mem[0], 32'hCAFEF00D);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    build(2, 32'h13579BDF, 32'h2468ACE0, 1'b0);
    run(0, lat, stalls);
    compare_model("midrst_reload", lat);
    check("midrst_mem0", seen_mem[0], 32'h13579BDF);
    check("midrst_mem1", seen_mem[1], 32'h2468ACE0);

    // reload from DONE
    do_reload();
    check("reload_in_ready", in_ready, 1);
    check("reload_done", done, 0);
    check("reload_err", err, 0);
    check("reload_cpu_rst", cpu_rst, 1);

`ifdef LOADER_CHECKSUM_EN
    stm = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run(0, lat, stalls);
    check("chk_good_done", done, 1);
    check("chk_good_lat", lat, 1);
    check("chk_good_data", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h11223344);
    stm = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run(0, lat, stalls);
    check("chk_bad_err", err, 1);
    check("chk_bad_cpu_rst", cpu_rst, 1);
    check("chk_bad_done", done, 0);
    check("chk_bad_nwr", wr_data_q.size(), 1);
    do_reload();
    check("chk_reload_in_ready", in_ready, 1);
    check("chk_reload_err", err, 0);
`endif

    // randomized loads against the reference model
    for (int r = 0; r < 40; r++) begin
      n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : int'($urandom_range(1, 4));
      bad  = CHK_EN && ($urandom_range(0, 3) == 0);
      mode = int'($urandom_range(0, 2));
      build(n, $urandom, $urandom, bad);
      run(mode, lat, stalls);
      compare_model($sformatf("rnd%0d", r), lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Upstream boot stage for the single-cycle CPU.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes those words sequentially into the instruction memory write port, starting at word 0.
- Holds the CPU in reset until loading completes, replacing bench-side memory preloading for hardware runs.

Parameters:
- ADDR_W, default 8: instruction memory word-address width. Depth is 2^ADDR_W words. Legal range 1..16.

Ports:
- clk  input  1: rising-edge clock.
- rst  input  1: asynchronous active-high reset.
- in_valid  input  1: input byte valid.
- in_data  input  8: input byte.
- in_ready  output  1: loader accepts a byte this cycle. A byte transfers when in_valid and in_ready are both high at a rising edge.
- reload  input  1: single-cycle request to restart loading. Honoured only in DONE or ERR.
- mem_we  output  1: instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_W: word address of the write.
- mem_wdata  output  32: word being written.
- cpu_rst  output  1: reset to the CPU. High while loading or in error.
- done  output  1: load completed successfully.
- err  output  1: load failed; CPU is held in reset.

Behaviour:
- Stream format:
  - Bytes 0-1: word count N, 16-bit big-endian.
  - Then 4*N bytes, each word big-endian (first byte goes to bits 31:24).
  - With LOADER_CHECKSUM_EN defined, one checksum byte follows.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0. State = CNT_HI. On the first edge after reset, in_ready=1.
- State CNT_HI: accept a byte into count[15:8], then go to CNT_LO.
- State CNT_LO: accept a byte into count[7:0]. Then:
  - if count > 2^ADDR_W, go to ERR;
  - else if count = 0, go to FIN;
  - else go to WORD with byte index 0.
- State WORD: accept bytes into a shift register, incrementing the byte index 0..3.
  - On acceptance of byte 3, the next edge registers mem_wdata = assembled word and mem_addr = word counter, and pulses mem_we for exactly one cycle.
  - The word counter increments after each write.
  - After the Nth word, go to FIN.
  - in_ready stays high during the mem_we cycle, so a back-to-back byte is accepted without a stall.
- State FIN (one cycle, in_ready=0): lets the final mem_we complete. Then go to DONE, or to CHK when checksum is enabled.
- State DONE: in_ready=0, done=1, cpu_rst=0, so the CPU leaves reset the cycle after the last mem_we at the earliest. mem_addr and mem_wdata hold their last values.
- State ERR: in_ready=0, err=1, cpu_rst=1, mem_we=0.
- reload:
  - In DONE or ERR, the next state is CNT_HI: cpu_rst=1, done=0, err=0, word counter and byte index cleared, memory contents untouched.
  - In any other state, reload is ignored.
- in_valid low in any accepting state: no state change, no write, partial shift contents retained.
- Reset mid-load: async return to the reset values. Words already written stay in memory, and the next load overwrites them from address 0.
- Maximum N = 2^ADDR_W writes addresses 0..2^ADDR_W-1. The word counter is ADDR_W+1 bits wide so the final compare does not wrap.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - State CHK follows FIN, with in_ready=1.
  - Accept one byte and compare it with the running XOR of all 4*N data bytes (count bytes excluded; the XOR is 0x00 when N=0).
  - Match: go to DONE. Mismatch: go to ERR. Words already written remain in memory.
- Not defined: no CHK state, no XOR logic, FIN goes straight to DONE.

Test Plan:
- Reset, then stream 00 02 | 20 08 00 05 | 01 09 50 20 with in_valid held high:
  - mem_we pulses twice: addr 0 data 0x20080005, then addr 1 data 0x01095020;
  - done=1 and cpu_rst=0 two cycles after the final byte.
- Stream 00 00 -> no mem_we; done=1 two cycles after the second byte (checksum off).
- With ADDR_W=4, stream count 00 11 (17) -> err=1 and cpu_rst=1 the cycle after the count byte; in_ready=0; no writes.
- Toggle in_valid every other cycle for N=1 with word 0xDEADBEEF -> a single write to addr 0 with data 0xDEADBEEF; no byte lost or duplicated.
- Assert rst after 6 bytes of an N=2 load, then release and send the full N=2 stream -> addr 0 and 1 rewritten correctly; done=1.
- LOADER_CHECKSUM_EN, N=1, word 0x11223344:
  - checksum byte 0x44 -> done=1;
  - checksum byte 0x45 -> err=1, cpu_rst=1;
  - then a reload pulse -> in_ready=1, state CNT_HI, err=0.
